// File: rtl/pingpong_tile_scheduler.sv
// pingpong_tile_scheduler: double-buffered tile fill/compute scheduler (start/num_tiles/tile_len/ext_base in, busy/done out, dma_* fill handshake, pe_* compute handshake)
module pingpong_tile_scheduler #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  num_tiles,
  input  logic [LEN_W-1:0]  tile_len,
  input  logic [ADDR_W-1:0] ext_base,
  output logic              busy,
  output logic              done,
  output logic              dma_req,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [LEN_W-1:0]  dma_len,
  output logic              dma_buf_sel,
  input  logic              dma_ack,
  input  logic              dma_done,
  output logic              pe_start,
  output logic              pe_buf_sel,
  input  logic              pe_done
);
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fill_e;
  typedef enum logic {C_IDLE, C_RUN} comp_e;
  fill_e             fill_q;
  comp_e             comp_q;
  logic              busy_q, done_q, dma_buf_q, pe_start_q, pe_buf_q, cbuf_q;
  logic [1:0]        full_q, full_nx;
  logic [ADDR_W-1:0] dma_addr_q, next_addr_q;
  logic [LEN_W-1:0]  len_q, num_q, fill_cnt_q, comp_cnt_q;
  logic              dma_fin, pe_fin, last, cbuf_nx, fill_go, comp_go;
  always_comb begin
    dma_fin = fill_q == F_WAIT && dma_done;
    pe_fin  = comp_q == C_RUN && pe_done;
    last    = pe_fin && comp_cnt_q + LEN_W'(1) == num_q;
    full_nx = (full_q | (dma_fin ? 2'b01 << dma_buf_q : 2'b00)) & ~(pe_fin ? 2'b01 << cbuf_q : 2'b00);
    cbuf_nx = cbuf_q ^ pe_fin;
    fill_go = busy_q && (fill_q == F_IDLE || dma_fin) && fill_cnt_q < num_q && !full_nx[fill_cnt_q[0]];
    comp_go = busy_q && !last && (comp_q == C_IDLE || pe_fin) && full_nx[cbuf_nx];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      fill_q      <= F_IDLE;
      comp_q      <= C_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dma_buf_q   <= 1'b0;
      pe_start_q  <= 1'b0;
      pe_buf_q    <= 1'b0;
      cbuf_q      <= 1'b0;
      full_q      <= '0;
      dma_addr_q  <= '0;
      next_addr_q <= '0;
      len_q       <= '0;
      num_q       <= '0;
      fill_cnt_q  <= '0;
      comp_cnt_q  <= '0;
    end else begin
      done_q     <= 1'b0;
      pe_start_q <= 1'b0;
      if (!busy_q) begin
        if (start) begin
          num_q      <= num_tiles;
          len_q      <= tile_len;
          busy_q     <= num_tiles != '0;
          done_q     <= num_tiles == '0;
          full_q     <= '0;
          cbuf_q     <= 1'b0;
          comp_cnt_q <= '0;
          fill_cnt_q <= '0;
          if (num_tiles != '0) begin
            fill_q      <= F_REQ;
            dma_addr_q  <= ext_base;
            next_addr_q <= ext_base + ADDR_W'(tile_len);
            dma_buf_q   <= 1'b0;
            fill_cnt_q  <= LEN_W'(1);
          end
        end
      end else if (last) begin
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
        fill_q     <= F_IDLE;
        comp_q     <= C_IDLE;
        full_q     <= '0;
        cbuf_q     <= 1'b0;
        fill_cnt_q <= '0;
        comp_cnt_q <= '0;
      end else begin
        full_q <= full_nx;
        cbuf_q <= cbuf_nx;
        if (pe_fin) comp_cnt_q <= comp_cnt_q + LEN_W'(1);
        // a finishing fill or compute may hand straight over to the next action without an idle cycle
        if (fill_go) begin
          fill_q      <= F_REQ;
          dma_addr_q  <= next_addr_q;
          next_addr_q <= next_addr_q + ADDR_W'(len_q);
          dma_buf_q   <= fill_cnt_q[0];
          fill_cnt_q  <= fill_cnt_q + LEN_W'(1);
        end else if (fill_q == F_REQ && dma_ack) fill_q <= F_WAIT;
        else if (dma_fin) fill_q <= F_IDLE;
        if (comp_go) begin
          comp_q     <= C_RUN;
          pe_start_q <= 1'b1;
          pe_buf_q   <= cbuf_nx;
        end else if (pe_fin) comp_q <= C_IDLE;
      end
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign dma_req     = fill_q == F_REQ;
  assign dma_addr    = dma_addr_q;
  assign dma_len     = len_q;
  assign dma_buf_sel = dma_buf_q;
  assign pe_start    = pe_start_q;
  assign pe_buf_sel  = pe_buf_q;
endmodule
